// File: rtl/mmio_out_fifo.sv
// mmio_out_fifo: memory-mapped byte FIFO feeding a valid/ready stream.
// Micro writes DATA to push, reads STATUS, writes CTRL to flush.
//
// Ports:
//   _iClk            clock, all state on rising edge
//   _iReset          synchronous reset, active-low
//   _iDataMemAddr    micro data-memory address
//   _iDataMemWData   micro data-memory write data
//   _iDataMemWrite   micro data-memory write strobe
//   _oSel            address hits the 3-register window
//   _oRData          register read data (STATUS only, else 0)
//   _oOutValid       downstream valid (FIFO not empty)
//   _oOutData        downstream data (FIFO head, fall-through)
//   _iOutReady       downstream ready
module mmio_out_fifo #(
    parameter int          DEPTH     = 8,
    parameter logic [7:0]  BASE_ADDR = 8'hF0
) (
    input  logic       _iClk,
    input  logic       _iReset,
    input  logic [7:0] _iDataMemAddr,
    input  logic [7:0] _iDataMemWData,
    input  logic       _iDataMemWrite,
    output logic       _oSel,
    output logic [7:0] _oRData,
    output logic       _oOutValid,
    output logic [7:0] _oOutData,
    input  logic       _iOutReady
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [7:0] ADDR_DATA = BASE_ADDR;
    localparam logic [7:0] ADDR_STAT = BASE_ADDR + 8'd1;
    localparam logic [7:0] ADDR_CTRL = BASE_ADDR + 8'd2;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic       push_req;
    logic       flush_req;
    logic       empty;
    logic       full;
    logic       pop;
    logic       push;
    logic [4:0] count_5;

    always_comb begin
        push_req  = _iDataMemWrite && (_iDataMemAddr == ADDR_DATA);
        flush_req = _iDataMemWrite && (_iDataMemAddr == ADDR_CTRL);
        empty     = (count_q == '0);
        full      = (count_q == CW'(DEPTH));
        pop       = !empty && _iOutReady;
        // A pop on the same edge frees the slot, so a full FIFO
        // still accepts the push.
        push      = push_req && (!full || pop);
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (flush_req) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (!push && pop) count_d = count_q - 1'b1;
            if (push_req && !push) ovf_d = 1'b1;
        end
    end

    always_comb begin
        count_5 = 5'(count_q);
        _oSel   = (_iDataMemAddr == ADDR_DATA) ||
                  (_iDataMemAddr == ADDR_STAT) ||
                  (_iDataMemAddr == ADDR_CTRL);
        if (_iDataMemAddr == ADDR_STAT)
            _oRData = {count_5, ovf_q, full, empty};
        else
            _oRData = 8'h00;
        _oOutValid = !empty;
        _oOutData  = mem_q[rd_ptr_q];
    end

    always_ff @(posedge _iClk) begin
        if (!_iReset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; pointers and count define what is live.
    always_ff @(posedge _iClk) begin
        if (_iReset && push) mem_q[wr_ptr_q] <= _iDataMemWData;
    end

endmodule

// File: tb/tb_mmio_out_fifo.sv
// tb_mmio_out_fifo: vector table plus queue-model scoreboard
// for mmio_out_fifo (DEPTH=8, BASE=F0).
module tb_mmio_out_fifo;

    localparam int         DEPTH = 8;
    localparam logic [7:0] BASE  = 8'hF0;
    localparam logic [7:0] A_DAT = 8'hF0;
    localparam logic [7:0] A_STA = 8'hF1;
    localparam logic [7:0] A_CTL = 8'hF2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic       wr = 1'b0;
    logic       rdy = 1'b0;
    logic       sel;
    logic [7:0] rdata;
    logic       ov;
    logic [7:0] od;

    always #5 clk = ~clk;

    mmio_out_fifo #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        ._iClk(clk),
        ._iReset(rst_n),
        ._iDataMemAddr(addr),
        ._iDataMemWData(wdata),
        ._iDataMemWrite(wr),
        ._oSel(sel),
        ._oRData(rdata),
        ._oOutValid(ov),
        ._oOutData(od),
        ._iOutReady(rdy)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0] sb[$];
    logic m_ovf = 1'b0;

    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        logic       r;
        logic       e_sel;
        logic [7:0] e_rd;
        logic       e_v;
        logic [7:0] e_d;
    } vec_t;

    vec_t tv[11];

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%02h required=%02h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] m_status();
        int n;
        n = sb.size();
        return {5'(n), m_ovf, (n == DEPTH), (n == 0)};
    endfunction

    // One clock: drive, check pre-edge outputs against the model,
    // then advance the model across the edge.
    task automatic cycle(input logic w, input logic [7:0] a,
                         input logic [7:0] d, input logic r,
                         input logic rs,
                         output logic o_sel, output logic o_v,
                         output logic [7:0] o_d,
                         output logic [7:0] o_rd);
        logic in_win;
        logic popm;
        @(negedge clk);
        wr = w; addr = a; wdata = d; rdy = r; rst_n = rs;
        #1;
        o_sel = sel; o_v = ov; o_d = od; o_rd = rdata;
        in_win = (a == A_DAT) || (a == A_STA) || (a == A_CTL);
        chk("sel", {7'b0, sel}, {7'b0, in_win});
        chk("rdata", rdata, (a == A_STA) ? m_status() : 8'h00);
        chk("valid", {7'b0, ov}, {7'b0, (sb.size() != 0)});
        if (sb.size() != 0) chk("sb_data", od, sb[0]);
        if (!rs) begin
            sb.delete();
            m_ovf = 1'b0;
        end else if (w && a == A_CTL) begin
            sb.delete();
            m_ovf = 1'b0;
        end else begin
            popm = (sb.size() != 0) && r;
            if (popm) void'(sb.pop_front());
            if (w && a == A_DAT) begin
                if (sb.size() < DEPTH) sb.push_back(d);
                else m_ovf = 1'b1;
            end
        end
        @(posedge clk);
    endtask

    logic       s_sel, s_v;
    logic [7:0] s_d, s_rd;

    task automatic push(input logic [7:0] d, input logic r);
        cycle(1'b1, A_DAT, d, r, 1'b1, s_sel, s_v, s_d, s_rd);
    endtask

    task automatic idle(input logic [7:0] a, input logic r);
        cycle(1'b0, a, 8'h00, r, 1'b1, s_sel, s_v, s_d, s_rd);
    endtask

    initial begin
        tv[0]  = '{1'b0, A_STA, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 8'h00};
        tv[1]  = '{1'b1, A_DAT, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00};
        tv[2]  = '{1'b1, A_DAT, 8'h3C, 1'b0, 1'b1, 8'h00, 1'b1, 8'hA5};
        tv[3]  = '{1'b0, A_STA, 8'h00, 1'b0, 1'b1, 8'h10, 1'b1, 8'hA5};
        tv[4]  = '{1'b0, A_STA, 8'h00, 1'b1, 1'b1, 8'h10, 1'b1, 8'hA5};
        tv[5]  = '{1'b0, A_STA, 8'h00, 1'b1, 1'b1, 8'h08, 1'b1, 8'h3C};
        tv[6]  = '{1'b0, A_STA, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 8'h00};
        tv[7]  = '{1'b0, 8'h10,  8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
        tv[8]  = '{1'b1, 8'hF3,  8'h99, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
        tv[9]  = '{1'b0, A_CTL, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00};
        tv[10] = '{1'b0, A_STA, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 8'h00};

        // Write attempted while held in reset must be ignored.
        rst_n = 1'b0; wr = 1'b1; addr = A_DAT; wdata = 8'hEE;
        repeat (3) @(posedge clk);
        @(negedge clk);
        wr = 1'b0;

        foreach (tv[i]) begin
            cycle(tv[i].w, tv[i].a, tv[i].d, tv[i].r, 1'b1,
                  s_sel, s_v, s_d, s_rd);
            chk($sformatf("vec%0d_sel", i), {7'b0, s_sel},
                {7'b0, tv[i].e_sel});
            chk($sformatf("vec%0d_rd", i), s_rd, tv[i].e_rd);
            chk($sformatf("vec%0d_v", i), {7'b0, s_v},
                {7'b0, tv[i].e_v});
            if (tv[i].e_v)
                chk($sformatf("vec%0d_d", i), s_d, tv[i].e_d);
        end

        // Overflow: 9 pushes, last one dropped.
        for (int i = 0; i < 9; i++) push(8'(i), 1'b0);
        idle(A_STA, 1'b0);
        chk("ovf_status", s_rd, 8'h46);
        for (int i = 0; i < 8; i++) begin
            idle(A_STA, 1'b1);
            chk($sformatf("drain%0d", i), s_d, 8'(i));
        end
        idle(A_STA, 1'b0);
        chk("drain_empty_v", {7'b0, s_v}, 8'h00);
        chk("ovf_sticky", s_rd, 8'h05);
        cycle(1'b1, A_CTL, 8'h00, 1'b0, 1'b1, s_sel, s_v, s_d, s_rd);

        // Full with concurrent pop: push accepted.
        for (int i = 0; i < 8; i++) push(8'(i + 8'h40), 1'b0);
        push(8'h77, 1'b1);
        idle(A_STA, 1'b0);
        chk("full_pop_status", s_rd, 8'h42);
        for (int i = 0; i < 8; i++) begin
            idle(A_STA, 1'b1);
            if (i == 7) chk("eighth_77", s_d, 8'h77);
        end

        // Flush with overflow set and a same-edge pop request.
        for (int i = 0; i < 9; i++) push(8'(i + 8'h60), 1'b0);
        for (int i = 0; i < 5; i++) idle(A_STA, 1'b1);
        idle(A_STA, 1'b0);
        chk("pre_flush_status", s_rd, 8'h1C);
        cycle(1'b1, A_CTL, 8'h00, 1'b1, 1'b1, s_sel, s_v, s_d, s_rd);
        idle(A_STA, 1'b0);
        chk("post_flush_status", s_rd, 8'h01);
        chk("post_flush_v", {7'b0, s_v}, 8'h00);
        push(8'h5A, 1'b0);
        idle(A_STA, 1'b0);
        chk("after_flush_d", s_d, 8'h5A);
        chk("after_flush_v", {7'b0, s_v}, 8'h01);

        // Reset beats a same-cycle push.
        cycle(1'b1, A_DAT, 8'hBB, 1'b1, 1'b0, s_sel, s_v, s_d, s_rd);
        idle(A_STA, 1'b0);
        chk("rst_prio_status", s_rd, 8'h01);

        // 20 pushes with ready toggling: wraps pointers, no loss.
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) push(8'(i / 2 + 8'h80), 1'b0);
            else idle(A_STA, 1'b1);
        end
        idle(A_STA, 1'b0);
        chk("stream_status", s_rd, 8'h01);

        // Reset mid-stream discards queued data.
        for (int i = 0; i < 3; i++) push(8'(i + 8'hC0), 1'b0);
        cycle(1'b0, A_STA, 8'h00, 1'b0, 1'b0, s_sel, s_v, s_d, s_rd);
        idle(A_STA, 1'b1);
        chk("mid_rst_v", {7'b0, s_v}, 8'h00);
        chk("mid_rst_status", s_rd, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
